// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU control unit / loader) for the single-port 256 x 16 data memory.
// Round-robin grant with a bounded loader lock; read data is steered back to the issuing requester.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
  localparam logic        OWN_CPU  = 1'b0;
  localparam logic        OWN_LDR  = 1'b1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]         rd_own_q, rd_own_d;     // {valid, owner}
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  cpu_rdata_q, ldr_rdata_q;
  logic               gnt_cpu, gnt_ldr;
  logic               wr_d;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = lock_cnt_q + CNT_W'(1);

  // Next-state and grant decision
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    gnt_cpu    = 1'b0;
    gnt_ldr    = 1'b0;
    unique case (state_q)
      ARB: begin
        if (cpu_req && (!ldr_req || last_q == OWN_LDR)) begin
          gnt_cpu = 1'b1;
          last_d  = OWN_CPU;
        end else if (ldr_req) begin
          gnt_ldr = 1'b1;
          last_d  = OWN_LDR;
          // A limit of one lets the entry grant itself exhaust the lock.
          if (ldr_lock && LOCK_MAX > CNT_W'(1)) begin
            state_d    = LOCKED;
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        last_d = OWN_LDR;
        if (ldr_req) begin
          gnt_ldr    = 1'b1;
          lock_cnt_d = cnt_inc;
          if (!ldr_lock || cnt_inc == LOCK_MAX) state_d = ARB;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (Reset) begin
      gnt_cpu = 1'b0;
      gnt_ldr = 1'b0;
    end
  end

  // Memory-side mux; address and write data hold when nothing is granted
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    if (gnt_cpu) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      wr_d    = cpu_wr;
    end else if (gnt_ldr) begin
      addr_d  = ldr_addr;
      wdata_d = ldr_wdata;
      wr_d    = ldr_wr;
    end
    rd_own_d = {(gnt_cpu && !cpu_wr) || (gnt_ldr && !ldr_wr), gnt_ldr};
  end

  assign cpu_gnt   = gnt_cpu;
  assign ldr_gnt   = gnt_ldr;
  assign mem_wr    = wr_d;
  assign mem_addr  = Reset ? '0 : addr_d;
  assign mem_wdata = Reset ? '0 : wdata_d;

  // Read return steered by the owner recorded at grant time
  assign cpu_rvalid = !Reset && rd_own_q[1] && (rd_own_q[0] == OWN_CPU);
  assign ldr_rvalid = !Reset && rd_own_q[1] && (rd_own_q[0] == OWN_LDR);
  assign cpu_rdata  = Reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
  assign ldr_rdata  = Reset ? '0 : (ldr_rvalid ? mem_rdata : ldr_rdata_q);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ARB;
      last_q      <= OWN_LDR;
      lock_cnt_q  <= '0;
      rd_own_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      rd_own_q    <= rd_own_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata;
      ldr_rdata_q <= ldr_rdata;
    end
  end

endmodule
